// File: rtl/cpu_pkg.sv
// Shared types and encodings for the 16-bit core control unit: FSM states,
// opcode/ext fields, ALU operation codes, branch conditions and PSR bit positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_ALU,
    S_LOAD,
    S_STORE,
    S_BRANCH,
    S_JUMP,
    S_JAL_LINK
  } state_t;

  // Major opcodes, ir[15:12]. Immediate ALU forms reuse the R-type ext code.
  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_ANDI    = 4'b0001;
  localparam logic [3:0] OP_ORI     = 4'b0010;
  localparam logic [3:0] OP_XORI    = 4'b0011;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_ADDI    = 4'b0101;
  localparam logic [3:0] OP_SHIFT   = 4'b1000;
  localparam logic [3:0] OP_SUBI    = 4'b1001;
  localparam logic [3:0] OP_CMPI    = 4'b1011;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_MOVI    = 4'b1101;
  localparam logic [3:0] OP_LUI     = 4'b1111;

  // Extended opcodes, ir[7:4].
  localparam logic [3:0] EXT_AND   = 4'b0001;
  localparam logic [3:0] EXT_OR    = 4'b0010;
  localparam logic [3:0] EXT_XOR   = 4'b0011;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_ADDU  = 4'b0110;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_MOV   = 4'b1101;
  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [4:0] ALU_AND   = 5'b00000;
  localparam logic [4:0] ALU_OR    = 5'b00001;
  localparam logic [4:0] ALU_XOR   = 5'b00010;
  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b00100;
  localparam logic [4:0] ALU_CMP   = 5'b00101;
  localparam logic [4:0] ALU_MOV   = 5'b00110;
  localparam logic [4:0] ALU_LSH   = 5'b00111;
  localparam logic [4:0] ALU_LUI   = 5'b01000;
  localparam logic [4:0] ALU_JCOND = 5'b01001;

  // ALU B-operand selects.
  localparam logic [1:0] B_RSRC = 2'd0;
  localparam logic [1:0] B_SIMM = 2'd1;
  localparam logic [1:0] B_ZIMM = 2'd2;

  // Condition codes, ir[11:8]. 1111 (never) falls through to not-taken.
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  typedef struct packed {
    logic       valid;
    logic [4:0] alu_op;
    logic [1:0] b_sel;
    logic       rf_we;
    logic       psr_en;
  } alu_dec_t;

  // Decode of every single-cycle ALU instruction; valid=0 for anything else.
  function automatic alu_dec_t decode_alu(input logic [15:0] instr);
    alu_dec_t   d;
    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] key;
    op       = instr[15:12];
    ext      = instr[7:4];
    key      = (op == OP_RTYPE) ? ext : op;
    d.valid  = 1'b1;
    d.alu_op = ALU_AND;
    d.rf_we  = 1'b1;
    d.psr_en = 1'b0;
    if (op == OP_RTYPE)
      d.b_sel = B_RSRC;
    else if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
      d.b_sel = B_ZIMM;
    else
      d.b_sel = B_SIMM;

    case (op)
      OP_SHIFT: begin
        d.alu_op = ALU_LSH;
        if (ext == EXT_LSH)
          d.b_sel = B_RSRC;
        else if (ext[3:1] != 3'b000)
          d.valid = 1'b0;
      end
      OP_LUI: begin
        d.alu_op = ALU_LUI;
        d.b_sel  = B_ZIMM;
      end
      OP_RTYPE, OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
        case (key)
          EXT_AND:  d.alu_op = ALU_AND;
          EXT_OR:   d.alu_op = ALU_OR;
          EXT_XOR:  d.alu_op = ALU_XOR;
          EXT_ADD: begin
            d.alu_op = ALU_ADD;
            d.psr_en = 1'b1;
          end
          // ADDU has no immediate form, so this key is only reachable from R-type.
          EXT_ADDU: d.alu_op = ALU_ADD;
          EXT_SUB: begin
            d.alu_op = ALU_SUB;
            d.psr_en = 1'b1;
          end
          EXT_CMP: begin
            d.alu_op = ALU_CMP;
            d.psr_en = 1'b1;
            d.rf_we  = 1'b0;
          end
          EXT_MOV:  d.alu_op = ALU_MOV;
          default:  d.valid  = 1'b0;
        endcase
      end
      default: d.valid = 1'b0;
    endcase

    if (!d.valid)
      d = '0;
    return d;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluation: condition code from ir[11:8] against the
// latched PSR flags. Purely combinational.
module cond_eval
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] psr_flags,
  output logic             take
);

  logic n, z, f, l, c;
  logic unused_flags;

  assign n = psr_flags[PSR_N];
  assign z = psr_flags[PSR_Z];
  assign f = psr_flags[PSR_F];
  assign l = psr_flags[PSR_L];
  assign c = psr_flags[PSR_C];

  assign unused_flags = ^{psr_flags[WIDTH-1:8], psr_flags[4:3], psr_flags[1]};

  // NOTE: assign a default before the case so every path drives take; a
  // missing assignment in always_comb infers a latch.
  always_comb begin
    take = 1'b0;
    case (cond)
      COND_EQ: take = z;
      COND_NE: take = !z;
      COND_CS: take = c;
      COND_CC: take = !c;
      COND_HI: take = l;
      COND_LS: take = !l;
      COND_GT: take = n;
      COND_LE: take = !n;
      COND_FS: take = f;
      COND_FC: take = !f;
      COND_LO: take = !l && !z;
      COND_HS: take = l || z;
      COND_LT: take = !n && !z;
      COND_GE: take = n || z;
      COND_UC: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: owns the instruction register, sequences
// fetch/decode/execute and drives the datapath selects and enables.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       mem_rdata,
  input  logic                   mem_ready,
  input  logic [WIDTH-1:0]       psr_flags,
  output logic [WIDTH-1:0]       ir,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   mem_addr_sel,
  output logic [ALU_CONT_BITS:0] alu_cont,
  output logic                   alu_a_sel,
  output logic [1:0]             alu_b_sel,
  output logic                   rf_we,
  output logic                   rf_wd_sel,
  output logic                   psr_en,
  output logic                   pc_en,
  output logic                   pc_src
);

  state_t     state;
  state_t     dispatch;
  alu_dec_t   alu_dec;
  logic [3:0] op;
  logic [3:0] ext;
  logic [4:0] alu_op;
  logic       cond_take;
  logic       is_jal;
  logic       jump_take;

  assign op      = ir[15:12];
  assign ext     = ir[7:4];
  assign alu_dec = decode_alu(ir[15:0]);

  cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
    .cond      (ir[11:8]),
    .psr_flags (psr_flags),
    .take      (cond_take)
  );

  // JAL reaches JUMP through JAL_LINK and always jumps, whatever its cond field.
  assign is_jal    = (op == OP_SPECIAL) && (ext == EXT_JAL);
  assign jump_take = cond_take || is_jal;

  always_comb begin
    dispatch = S_FETCH;
    if (alu_dec.valid)
      dispatch = S_ALU;
    else if (op == OP_BCOND)
      dispatch = S_BRANCH;
    else if (op == OP_SPECIAL) begin
      case (ext)
        EXT_LOAD:  dispatch = S_LOAD;
        EXT_STOR:  dispatch = S_STORE;
        EXT_JAL:   dispatch = S_JAL_LINK;
        EXT_JCOND: dispatch = S_JUMP;
        default:   dispatch = S_FETCH;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE:   state <= dispatch;
        S_LOAD,
        S_STORE:    if (mem_ready) state <= S_FETCH;
        S_JAL_LINK: state <= S_JUMP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced idle while reset is high so an interrupted handshake
  // or register write cannot leak out during the reset cycle.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_op       = ALU_AND;
    alu_a_sel    = 1'b0;
    alu_b_sel    = B_RSRC;
    rf_we        = 1'b0;
    rf_wd_sel    = 1'b0;
    psr_en       = 1'b0;
    pc_en        = 1'b0;
    pc_src       = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          pc_en   = mem_ready;
        end
        S_ALU: begin
          alu_op    = alu_dec.alu_op;
          alu_b_sel = alu_dec.b_sel;
          rf_we     = alu_dec.rf_we;
          psr_en    = alu_dec.psr_en;
        end
        S_LOAD: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          rf_wd_sel    = 1'b1;
          rf_we        = mem_ready;
        end
        S_STORE: begin
          mem_req      = 1'b1;
          mem_we       = 1'b1;
          mem_addr_sel = 1'b1;
        end
        S_BRANCH: begin
          // PC already points past the branch, so target = PC + disp.
          if (cond_take) begin
            alu_a_sel = 1'b1;
            alu_b_sel = B_SIMM;
            alu_op    = ALU_ADD;
            pc_en     = 1'b1;
            pc_src    = 1'b1;
          end
        end
        S_JAL_LINK: begin
          alu_a_sel = 1'b1;
          alu_op    = ALU_JCOND;
          rf_we     = 1'b1;
        end
        S_JUMP: begin
          if (jump_take) begin
            alu_op = ALU_JCOND;
            pc_en  = 1'b1;
            pc_src = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_cont = {1'b0, ALU_CONT_BITS'(alu_op)};

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: stimulus pushes the hand-computed output
// vector for each cycle, a monitor pops and compares at the falling edge.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] psr_flags = '0;
  logic [15:0] ir;
  logic        mem_req, mem_we, mem_addr_sel;
  logic [5:0]  alu_cont;
  logic        alu_a_sel;
  logic [1:0]  alu_b_sel;
  logic        rf_we, rf_wd_sel, psr_en, pc_en, pc_src;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic [5:0]  alu_cont;
    logic        alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic        rf_we;
    logic        rf_wd_sel;
    logic        psr_en;
    logic        pc_en;
    logic        pc_src;
    logic [15:0] ir;
  } out_t;

  typedef struct {
    out_t  e;
    string name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cur_ir = '0;
  logic [15:0] cur_flags = '0;

  always #5 clk = ~clk;

  cpu_ctrl #(.WIDTH(16), .ALU_CONT_BITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .psr_flags    (psr_flags),
    .ir           (ir),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .alu_cont     (alu_cont),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .rf_we        (rf_we),
    .rf_wd_sel    (rf_wd_sel),
    .psr_en       (psr_en),
    .pc_en        (pc_en),
    .pc_src       (pc_src)
  );

  function automatic string fmt(input out_t o);
    return $sformatf("req=%b we=%b addr_sel=%b alu=%b a_sel=%b b_sel=%0d rf_we=%b wd_sel=%b psr_en=%b pc_en=%b pc_src=%b ir=%h",
                     o.mem_req, o.mem_we, o.mem_addr_sel, o.alu_cont, o.alu_a_sel, o.alu_b_sel,
                     o.rf_we, o.rf_wd_sel, o.psr_en, o.pc_en, o.pc_src, o.ir);
  endfunction

  function automatic out_t sample();
    out_t o;
    o.mem_req      = mem_req;
    o.mem_we       = mem_we;
    o.mem_addr_sel = mem_addr_sel;
    o.alu_cont     = alu_cont;
    o.alu_a_sel    = alu_a_sel;
    o.alu_b_sel    = alu_b_sel;
    o.rf_we        = rf_we;
    o.rf_wd_sel    = rf_wd_sel;
    o.psr_en       = psr_en;
    o.pc_en        = pc_en;
    o.pc_src       = pc_src;
    o.ir           = ir;
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @%0t: got [%s] required [%s]", name, $time, fmt(act), fmt(req));
    end
  endtask

  // Monitor: one expected vector per stimulus cycle, compared mid-cycle.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        check(it.name, sample(), it.e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic out_t base();
    out_t e;
    e    = '0;
    e.ir = cur_ir;
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic rdy, input logic [15:0] rdata,
                     input out_t e, input string name);
    exp_t x;
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    mem_rdata = rdata;
    psr_flags = cur_flags;
    x.e       = e;
    x.name    = name;
    exp_q.push_back(x);
  endtask

  task automatic fetch(input logic [15:0] instr, input int waits, input logic dec_rdy);
    out_t e;
    for (int i = 0; i < waits; i++) begin
      e = base(); e.mem_req = 1'b1;
      cyc(1'b0, 1'b0, 16'hDEAD, e, "fetch_wait");
    end
    e = base(); e.mem_req = 1'b1; e.pc_en = 1'b1;
    cyc(1'b0, 1'b1, instr, e, "fetch_ready");
    cur_ir = instr;
    e = base();
    cyc(1'b0, dec_rdy, 16'hBEEF, e, "decode");
  endtask

  task automatic alu_op(input logic [15:0] instr, input logic [5:0] alu, input logic [1:0] bsel,
                        input logic we, input logic psr, input string name);
    out_t e;
    fetch(instr, 0, 1'b0);
    e = base(); e.alu_cont = alu; e.alu_b_sel = bsel; e.rf_we = we; e.psr_en = psr;
    cyc(1'b0, 1'b0, 16'h0000, e, name);
  endtask

  task automatic branch(input logic [15:0] instr, input logic [15:0] flags,
                        input logic taken, input string name);
    out_t e;
    cur_flags = flags;
    fetch(instr, 0, 1'b0);
    e = base();
    if (taken) begin
      e.alu_a_sel = 1'b1; e.alu_b_sel = 2'd1; e.alu_cont = 6'b000011;
      e.pc_en = 1'b1; e.pc_src = 1'b1;
    end
    cyc(1'b0, 1'b0, 16'h0000, e, name);
  endtask

  task automatic jump(input logic [15:0] instr, input logic [15:0] flags, input logic taken,
                      input logic link, input string name);
    out_t e;
    cur_flags = flags;
    fetch(instr, 0, 1'b0);
    if (link) begin
      e = base(); e.alu_a_sel = 1'b1; e.alu_cont = 6'b001001; e.rf_we = 1'b1;
      cyc(1'b0, 1'b0, 16'h0000, e, "jal_link");
    end
    e = base();
    if (taken) begin
      e.alu_cont = 6'b001001; e.pc_en = 1'b1; e.pc_src = 1'b1;
    end
    cyc(1'b0, 1'b0, 16'h0000, e, name);
  endtask

  task automatic load(input logic [15:0] instr, input int waits);
    out_t e;
    fetch(instr, 1, 1'b1);
    for (int i = 0; i < waits; i++) begin
      e = base(); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.rf_wd_sel = 1'b1;
      cyc(1'b0, 1'b0, 16'h1234, e, "load_wait");
    end
    e = base(); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.rf_wd_sel = 1'b1; e.rf_we = 1'b1;
    cyc(1'b0, 1'b1, 16'h1234, e, "load_ready");
  endtask

  task automatic store(input logic [15:0] instr, input int waits);
    out_t e;
    fetch(instr, 0, 1'b0);
    for (int i = 0; i <= waits; i++) begin
      e = base(); e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1;
      cyc(1'b0, (i == waits), 16'h0000, e, (i == waits) ? "store_ready" : "store_wait");
    end
  endtask

  initial begin
    out_t e;

    cyc(1'b1, 1'b0, 16'h0000, base(), "reset_idle");
    cyc(1'b1, 1'b1, 16'h0152, base(), "reset_ignores_ready");

    // ALU class: opcode, operand select, write and flag enables.
    alu_op(16'h0152, 6'b000011, 2'd0, 1'b1, 1'b1, "add");
    alu_op(16'h0162, 6'b000011, 2'd0, 1'b1, 1'b0, "addu");
    alu_op(16'h51FF, 6'b000011, 2'd1, 1'b1, 1'b1, "addi");
    alu_op(16'h11FF, 6'b000000, 2'd2, 1'b1, 1'b0, "andi");
    alu_op(16'hB105, 6'b000101, 2'd1, 1'b0, 1'b1, "cmpi");
    alu_op(16'h0132, 6'b000010, 2'd0, 1'b1, 1'b0, "xor");
    alu_op(16'h0192, 6'b000100, 2'd0, 1'b1, 1'b1, "sub");
    alu_op(16'hD380, 6'b000110, 2'd1, 1'b1, 1'b0, "movi");
    alu_op(16'h8201, 6'b000111, 2'd1, 1'b1, 1'b0, "lshi");
    alu_op(16'h8243, 6'b000111, 2'd0, 1'b1, 1'b0, "lsh");
    alu_op(16'hF1AB, 6'b001000, 2'd2, 1'b1, 1'b0, "lui");

    // Conditional branches against the latched flags.
    branch(16'hC0FE, 16'h0040, 1'b1, "beq_z1");
    branch(16'hC0FE, 16'h0000, 1'b0, "beq_z0");
    branch(16'hCEFE, 16'h0000, 1'b1, "buc");
    branch(16'hCFFE, 16'hFFFF, 1'b0, "bnever");
    branch(16'hCA00, 16'h0000, 1'b1, "blo");
    branch(16'hCB00, 16'h0000, 1'b0, "bhs");
    branch(16'hCD00, 16'h0080, 1'b1, "bge");
    branch(16'hC200, 16'h0001, 1'b1, "bcs");

    // Undefined encodings fall straight back to FETCH after DECODE.
    fetch(16'h0000, 0, 1'b0);
    fetch(16'h6123, 0, 1'b0);

    load(16'h4203, 3);
    store(16'h4241, 1);

    jump(16'h4E85, 16'h0000, 1'b1, 1'b1, "jal_jump");
    jump(16'h4F85, 16'h0000, 1'b1, 1'b1, "jal_forced");
    jump(16'h4EC3, 16'h0000, 1'b1, 1'b0, "jcond_uc");
    jump(16'h4FC3, 16'hFFFF, 1'b0, 1'b0, "jcond_never");
    jump(16'h40C3, 16'h0040, 1'b1, 1'b0, "jcond_eq");

    // Reset arriving while a load is waiting on memory.
    cur_flags = '0;
    fetch(16'h4203, 0, 1'b0);
    e = base(); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.rf_wd_sel = 1'b1;
    cyc(1'b0, 1'b0, 16'h0000, e, "load_wait_pre_reset");
    cyc(1'b1, 1'b0, 16'h0000, base(), "reset_mid_load");
    cur_ir = '0;
    cyc(1'b1, 1'b1, 16'h0152, base(), "reset_after_load");
    alu_op(16'h0152, 6'b000011, 2'd0, 1'b1, 1'b1, "add_after_reset");

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control unit for the 16-bit core. Owns the instruction register, fetches over a req/ready memory handshake, and decodes each instruction. Drives the register-file/ALU datapath: `alu_cont`, operand selects, write enables, the PSR latch enable, and the PC update. Evaluates branch and jump conditions from the latched `psr_flags`.

## Interface
- `WIDTH`, 16: datapath and instruction width.
- `ALU_CONT_BITS`, 5: `alu_cont` port is `ALU_CONT_BITS+1` bits; the MSB is always 0.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `mem_rdata`  in  WIDTH: memory read data (instruction or load data).
- `mem_ready`  in  1: memory completes the current request this cycle.
- `psr_flags`  in  WIDTH: latched PSR (bit7 N, bit6 Z, bit5 F, bit2 L, bit0 C).
- `ir`  out  WIDTH: instruction register. Datapath takes Rdest=`ir[11:8]` and Rsrc=`ir[3:0]` from it.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: store qualifier for `mem_req`.
- `mem_addr_sel`  out  1: 0=PC, 1=Rsrc.
- `alu_cont`  out  ALU_CONT_BITS+1: ALU operation code.
- `alu_a_sel`  out  1: 0=Rdest, 1=PC.
- `alu_b_sel`  out  2: 0=Rsrc, 1=sign-extended imm8, 2=zero-extended imm8.
- `rf_we`  out  1: register write of Rdest.
- `rf_wd_sel`  out  1: 0=`alu_out`, 1=`mem_rdata`.
- `psr_en`  out  1: latch ALU flags into PSR.
- `pc_en`  out  1: PC update.
- `pc_src`  out  1: 0=PC+1, 1=`alu_out`.

## Operation
- Decoded opcode groups (`ir[15:12]`, ext = `ir[7:4]`):
  - 0000 R-type, by ext: AND 0001, OR 0010, XOR 0011, ADD 0101, ADDU 0110, SUB 1001, CMP 1011, MOV 1101.
  - Immediate forms share the ext code as opcode: ANDI/ORI/XORI zero-extend; ADDI/SUBI/CMPI/MOVI sign-extend.
  - 1000 LSH (ext 0100, Rsrc amount) and LSHI (ext 000x, sign-extended imm).
  - 1111 LUI.
  - 0100 special: LOAD ext 0000, STOR 0100, JAL 1000, Jcond 1100.
  - 1100 Bcond with sign-extended 8-bit displacement.
- ALU codes: AND 00000, OR 00001, XOR 00010, ADD 00011, SUB 00100, CMP 00101, MOV 00110, LSH 00111, LUI 01000, JCOND (pass A) 01001.
- `psr_en`=1 only for ADD/ADDI/SUB/SUBI/CMP/CMPI. ADDU uses ADD with `psr_en`=0.
- CMP/CMPI set `psr_en` but not `rf_we`.
- Condition code = `ir[11:8]`:
  - EQ Z, NE !Z, CS C, CC !C, HI L, LS !L, GT N, LE !N, FS F, FC !F.
  - LO !L&!Z, HS L|Z, LT !N&!Z, GE N|Z, UC 1, 1111 never.
- States and transitions:
  - FETCH: `mem_req`=1, `mem_addr_sel`=0. On `mem_ready`: load `ir`, `pc_en`=1 with `pc_src`=0, then go to DECODE. Otherwise hold.
  - DECODE: no enables asserted. Dispatch to ALU, LOAD, STORE, BRANCH, JUMP, or JAL_LINK. Undefined encodings go to FETCH (NOP).
  - ALU: one cycle with `rf_we`/`psr_en` per opcode, then FETCH.
  - LOAD: `mem_req`=1, `mem_addr_sel`=1. Hold until `mem_ready`; that cycle `rf_we`=1, `rf_wd_sel`=1. Then FETCH.
  - STORE: `mem_req`=`mem_we`=1, `mem_addr_sel`=1. Hold until `mem_ready`, then FETCH.
  - BRANCH: if the condition is true, `alu_a_sel`=1, `alu_b_sel`=1, ADD, `pc_en`=1, `pc_src`=1. The target is the incremented PC + disp. Then FETCH.
  - JAL_LINK: `alu_a_sel`=1, JCOND, `rf_we`=1 (Rdest = incremented PC). Then JUMP, with the condition forced true.
  - JUMP: if the condition is true, `alu_b_sel`=0 and the datapath routes Rsrc to A via JCOND; `pc_en`=1, `pc_src`=1. Then FETCH.
- Condition uses `psr_flags` sampled in BRANCH/JUMP, so the flags from the previous instruction are visible.

## Timing
- Reset: state=FETCH, `ir`=0. Every enable and `mem_req`/`mem_we` output is 0 in the reset cycle. Defaults: selects 0, `alu_cont`=0.
- Reset asserted in any state (including mid-handshake) aborts the operation. The first `mem_req` is issued the cycle after reset deasserts.
- All outputs are a Moore decode of state plus `ir`, except the `mem_ready`-gated enables (`ir` load, `pc_en` in FETCH, `rf_we` in LOAD), which are combinational on `mem_ready`.
- `mem_req` stays high and the address/we stay stable until `mem_ready`. `mem_ready` outside FETCH/LOAD/STORE is ignored.
- Cycle counts with zero-wait memory:
  - ALU op: 3.
  - Branch/Jcond: 3.
  - LOAD/STOR: 3 + wait cycles.
  - JAL: 4.

## Structure
- Package `cpu_pkg`: state enum, opcode/ext constants, ALU code constants, condition-code constants, PSR bit indices.
- Sub-module `cond_eval` (combinational): condition code + `psr_flags` → take.

## Test plan
- Reset mid-LOAD with `mem_ready`=0 → next cycle FETCH, `mem_req`=0 during reset, no `rf_we`.
- `ir`=0x0152 (ADD R1,R2) → DECODE then ALU with `alu_cont`=00011, `rf_we`=1, `psr_en`=1, `alu_b_sel`=0. ADDU 0x0162 → `psr_en`=0.
- ADDI 0x51FF → `alu_b_sel`=1. ANDI 0x11FF → `alu_b_sel`=2. CMPI 0xB105 → `psr_en`=1, `rf_we`=0.
- Bcond 0xC0FE with Z=1 → `pc_en`=1, `pc_src`=1, ADD. With Z=0 → `pc_en`=0. Cond 1110 is always taken; 1111 is never taken.
- LOAD 0x4203 with `mem_ready` low for 3 cycles → `mem_req` held, `mem_addr_sel`=1. `rf_we` pulses exactly in the ready cycle with `rf_wd_sel`=1.
- JAL 0x4E85 → JAL_LINK `rf_we`=1 with `alu_a_sel`=1, then JUMP `pc_en`=1. Total 4 cycles from FETCH.
